axi_lite_led_slave: RTL and testbench
=====================================

// Module: axi_lite_led_slave
// PURPOSE
//   AXI4-Lite slave holding the LED output register. Sits directly downstream of the
//   JTAG-AXI bridge master inside Jtag_Axi_Top: it consumes bridge write/read
//   transactions and drives led_pins. Unmapped accesses are rejected without side effects.
// PARAMETERS
//   AXI_ADDR_WIDTH  32            address width
//   AXI_DATA_WIDTH  32            data width (only 32 supported)
//   BASE_ADDR       32'h43C00000  base of 4 KB register window
//   LED_WIDTH       4             number of LED outputs (1..32)
//   LED_RESET_VAL   '0            led_pins / LED register value after reset
// PORTS
//   sys_clk        in   1                  system clock; all logic on its rising edge
//   sys_resetn     in   1                  asynchronous, active-low reset
//   s_axi_awaddr   in   AXI_ADDR_WIDTH     write address
//   s_axi_awvalid  in   1                  write address valid
//   s_axi_awready  out  1                  write address ready
//   s_axi_wdata    in   AXI_DATA_WIDTH     write data
//   s_axi_wstrb    in   AXI_DATA_WIDTH/8   write byte strobes
//   s_axi_wvalid   in   1                  write data valid
//   s_axi_wready   out  1                  write data ready
//   s_axi_bresp    out  2                  write response
//   s_axi_bvalid   out  1                  write response valid
//   s_axi_bready   in   1                  write response ready
//   s_axi_araddr   in   AXI_ADDR_WIDTH     read address
//   s_axi_arvalid  in   1                  read address valid
//   s_axi_arready  out  1                  read address ready
//   s_axi_rdata    out  AXI_DATA_WIDTH     read data
//   s_axi_rresp    out  2                  read response
//   s_axi_rvalid   out  1                  read data valid
//   s_axi_rready   in   1                  read data ready
//   led_pins       out  LED_WIDTH          registered LED drive
// BEHAVIOUR
//   Reset (async assert, sync release): led reg = LED_RESET_VAL; all valid/ready = 0;
//     bresp/rresp/rdata = 0. First cycle after release: awready/wready/arready = 1.
//   Register map (offset = addr - BASE_ADDR, bits [1:0] ignored):
//     0x0 LED   RW  [LED_WIDTH-1:0], upper bits read 0
//     0x4 ID    RO  32'h4C454401; write -> SLVERR, no effect
//     all other offsets, or addr outside [BASE_ADDR, BASE_ADDR+0xFFF] -> SLVERR, no effect
//   Write path: AW and W accepted independently into one-deep holding regs;
//     awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
//     Cycle after both held: register updated (if OKAY and wstrb[0]=1), bvalid=1 with bresp.
//     wstrb[0]=0 to LED -> OKAY, LED unchanged. Min latency AW+W same cycle -> bvalid +1 cycle.
//     bvalid/bresp held stable until bready; holding regs cleared on B handshake.
//   Read path: arready = !rvalid. On AR handshake: rvalid=1 next cycle with rdata/rresp;
//     held stable until rready; SLVERR reads return rdata=0.
//   Write FSM: W_IDLE -> W_RESP (both held) -> W_IDLE (bready). Read FSM: R_IDLE -> R_DATA -> R_IDLE.
//   Simultaneous read and write of LED in same cycle: read returns pre-write value.
//   led_pins = LED register directly (no combinational path from AXI inputs).
//   Reset mid-transaction: outstanding transaction dropped, no response issued.
// CONFIGURATION
//   AXI_LED_TXN_CNT_EN defined: offset 0x8 = RO 32-bit counter of OKAY writes to LED,
//     wraps 0xFFFFFFFF->0, reset 0; write to 0x8 -> SLVERR.
//   Undefined: offset 0x8 unmapped (SLVERR on read and write), no counter logic.
// STRUCTURE
//   jtag_axi_pkg: AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, offsets LED_OFS/ID_OFS/CNT_OFS,
//     LED_ID_VALUE, write/read FSM state enums.
//   Sub-module axi_lite_led_decode: combinational address -> {hit_led, hit_id, hit_cnt, err}.
// TESTING
//   Reset: sys_resetn=0 10 cycles -> led_pins=LED_RESET_VAL, bvalid=rvalid=0; readies 1 after release.
//   AW+W same cycle 0x43C00000/0xA, bready=1 -> bvalid next cycle, bresp=OKAY, led_pins=4'b1010.
//   W two cycles before AW, data 0x5 -> no write until AW; then bresp=OKAY, led_pins=4'b0101.
//   Write 0x43C00004/0xDEADBEEF -> bresp=SLVERR, led_pins unchanged; read 0x4 -> 0x4C454401 OKAY.
//   Read 0x43C00010 and 0x40000000 -> rresp=SLVERR, rdata=0; bready/rready held low 5 cycles -> outputs stable.
//   With AXI_LED_TXN_CNT_EN: 3 LED writes + 1 wstrb=0 write -> read 0x8 = 4; without: SLVERR.

Source files
------------

// File: rtl/jtag_axi_pkg.sv
// Shared AXI4-Lite constants, LED register map and FSM state types for the
// JTAG-AXI LED slave.
package jtag_axi_pkg;

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;

    localparam logic [11:0] LED_OFS = 12'h000;
    localparam logic [11:0] ID_OFS  = 12'h004;
    localparam logic [11:0] CNT_OFS = 12'h008;

    localparam logic [31:0] LED_ID_VALUE = 32'h4C454401;

    typedef enum logic { W_IDLE, W_RESP } wr_state_e;
    typedef enum logic { R_IDLE, R_DATA } rd_state_e;

    typedef struct packed {
        logic hit_led;
        logic hit_id;
        logic hit_cnt;
        logic err;
    } dec_t;

endpackage

// File: rtl/axi_lite_led_decode.sv
// Combinational address decoder for the LED slave's 4 KB window.
// Offset 0x8 only decodes when AXI_LED_TXN_CNT_EN is defined.
module axi_lite_led_decode
    import jtag_axi_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h43C00000
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    output dec_t                      dec_o
);

    logic [AXI_ADDR_WIDTH-1:0] ofs;
    logic                      in_win;
    logic [11:0]               word_ofs;
    logic                      unused_lsb;

    // Unsigned wrap puts addresses below BASE_ADDR far outside the window.
    assign ofs        = addr_i - BASE_ADDR;
    assign in_win     = (ofs >> 12) == '0;
    assign word_ofs   = {ofs[11:2], 2'b00};
    assign unused_lsb = ^ofs[1:0];

    always_comb begin
        dec_o = '0;
        if (in_win) begin
            dec_o.hit_led = (word_ofs == LED_OFS);
            dec_o.hit_id  = (word_ofs == ID_OFS);
`ifdef AXI_LED_TXN_CNT_EN
            dec_o.hit_cnt = (word_ofs == CNT_OFS);
`endif
        end
        dec_o.err = !(dec_o.hit_led || dec_o.hit_id || dec_o.hit_cnt);
    end

endmodule

// File: rtl/axi_lite_led_slave.sv
// AXI4-Lite slave owning the LED output register behind the JTAG-AXI bridge.
// Define AXI_LED_TXN_CNT_EN to expose a read-only LED write counter at offset 0x8.
module axi_lite_led_slave
    import jtag_axi_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h43C00000,
    parameter int                        LED_WIDTH      = 4,
    parameter logic [LED_WIDTH-1:0]      LED_RESET_VAL  = '0
) (
    input  logic                        sys_clk,
    input  logic                        sys_resetn,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [LED_WIDTH-1:0]        led_pins
);

    // Keeps every ready low until the first edge after reset release.
    logic                        init_q;

    wr_state_e                   wstate_q;
    logic                        aw_held_q;
    logic                        w_held_q;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic                        bvalid_q;
    logic [1:0]                  bresp_q;

    rd_state_e                   rstate_q;
    logic                        rvalid_q;
    logic [1:0]                  rresp_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;

    logic [LED_WIDTH-1:0]        led_q;
    logic [LED_WIDTH-1:0]        led_d;

    dec_t                        wdec;
    dec_t                        rdec;
    logic                        commit;
    logic                        wr_ok;
    logic [AXI_DATA_WIDTH-1:0]   rd_word;
    logic                        unused_ok;

    axi_lite_led_decode #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .BASE_ADDR      (BASE_ADDR)
    ) u_wdec (
        .addr_i (awaddr_q),
        .dec_o  (wdec)
    );

    axi_lite_led_decode #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .BASE_ADDR      (BASE_ADDR)
    ) u_rdec (
        .addr_i (s_axi_araddr),
        .dec_o  (rdec)
    );

    assign s_axi_awready = init_q && !aw_held_q && !bvalid_q;
    assign s_axi_wready  = init_q && !w_held_q && !bvalid_q;
    assign s_axi_arready = init_q && !rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign led_pins      = led_q;

    // Only the LED register is writable; ID and counter are read-only.
    assign wr_ok  = wdec.hit_led;
    assign commit = (wstate_q == W_IDLE) && aw_held_q && w_held_q;
    assign led_d  = (commit && wr_ok && wstrb_q[0]) ? wdata_q[LED_WIDTH-1:0] : led_q;

    assign unused_ok = ^{wdata_q, wstrb_q, wdec, rdec.err, rdec.hit_cnt};

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            init_q    <= 1'b0;
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
        end else begin
            init_q <= 1'b1;
            case (wstate_q)
                W_IDLE: begin
                    if (aw_held_q && w_held_q) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        wstate_q <= W_RESP;
                    end else begin
                        if (s_axi_awvalid && s_axi_awready) begin
                            aw_held_q <= 1'b1;
                            awaddr_q  <= s_axi_awaddr;
                        end
                        if (s_axi_wvalid && s_axi_wready) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= s_axi_wdata;
                            wstrb_q  <= s_axi_wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) led_q <= LED_RESET_VAL;
        else             led_q <= led_d;
    end

`ifdef AXI_LED_TXN_CNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Counts every OKAY LED write, including ones whose strobe leaves the LEDs alone.
    assign cnt_d = cnt_q + ((commit && wr_ok) ? 32'd1 : 32'd0);

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) cnt_q <= '0;
        else             cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        rd_word = '0;
        if (rdec.hit_led)     rd_word[LED_WIDTH-1:0] = led_q;
        else if (rdec.hit_id) rd_word = AXI_DATA_WIDTH'(LED_ID_VALUE);
`ifdef AXI_LED_TXN_CNT_EN
        else if (rdec.hit_cnt) rd_word = AXI_DATA_WIDTH'(cnt_q);
`endif
    end

    // rd_word samples led_q before any write committing on the same edge.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= AXI_RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_word;
                        rresp_q  <= rdec.err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        rstate_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        rstate_q <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_led_slave.sv
// Randomized bench for axi_lite_led_slave: per-cycle compare against a
// behavioural model of the register map, plus directed literal checks.
module tb_axi_lite_led_slave;

    localparam logic [31:0] BASE   = 32'h43C00000;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
    localparam logic [31:0] ID_VAL = 32'h4C454401;

    logic        sys_clk = 1'b0;
    logic        sys_resetn = 1'b0;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [3:0]  led_pins;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    axi_lite_led_slave dut (
        .sys_clk       (sys_clk),
        .sys_resetn    (sys_resetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .led_pins      (led_pins)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          init_m, awh, wh, bv_m, rv_m;
    logic [31:0] awa_m, wd_m, rdata_m, cnt_m;
    logic [3:0]  ws_m, led_m;
    logic [1:0]  bresp_m, rresp_m;

    function automatic void model_read(input logic [31:0] a, output logic [1:0] resp,
                                       output logic [31:0] data);
        logic [31:0] o;
        o    = a - BASE;
        resp = SLVERR;
        data = '0;
        if (o < 32'h1000) begin
            if (o[11:2] == 10'd0) begin
                resp = OKAY;
                data = {28'b0, led_m};
            end else if (o[11:2] == 10'd1) begin
                resp = OKAY;
                data = ID_VAL;
            end
`ifdef AXI_LED_TXN_CNT_EN
            else if (o[11:2] == 10'd2) begin
                resp = OKAY;
                data = cnt_m;
            end
`endif
        end
    endfunction

    // Inputs change only at posedge+1, so values seen here are what the next edge samples.
    always @(negedge sys_clk) begin
        logic        awr, wr, arr;
        logic [31:0] o;
        if (!sys_resetn) begin
            chk("reset_outputs", {led_pins, s_axi_awready, s_axi_wready, s_axi_arready,
                                  s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata},
                64'd0);
            init_m = 0; awh = 0; wh = 0; bv_m = 0; rv_m = 0;
            led_m = 4'h0; cnt_m = 0; bresp_m = OKAY; rresp_m = OKAY; rdata_m = 0;
        end else begin
            awr = init_m && !awh && !bv_m;
            wr  = init_m && !wh && !bv_m;
            arr = init_m && !rv_m;
            chk("led_pins", led_pins, led_m);
            chk("awready", s_axi_awready, awr);
            chk("wready", s_axi_wready, wr);
            chk("arready", s_axi_arready, arr);
            chk("bvalid", s_axi_bvalid, bv_m);
            chk("rvalid", s_axi_rvalid, rv_m);
            if (bv_m) chk("bresp", s_axi_bresp, bresp_m);
            if (rv_m) begin
                chk("rresp", s_axi_rresp, rresp_m);
                chk("rdata", s_axi_rdata, rdata_m);
            end
            // read first: it must see the LED value before a same-edge write
            if (rv_m) begin
                if (s_axi_rready) rv_m = 0;
            end else if (s_axi_arvalid && arr) begin
                model_read(s_axi_araddr, rresp_m, rdata_m);
                rv_m = 1;
            end
            if (bv_m) begin
                if (s_axi_bready) begin bv_m = 0; awh = 0; wh = 0; end
            end else if (awh && wh) begin
                o = awa_m - BASE;
                if (o < 32'h1000 && o[11:2] == 10'd0) begin
                    bresp_m = OKAY;
                    cnt_m   = cnt_m + 1;
                    if (ws_m[0]) led_m = wd_m[3:0];
                end else begin
                    bresp_m = SLVERR;
                end
                bv_m = 1;
            end else begin
                if (s_axi_awvalid && awr) begin awh = 1; awa_m = s_axi_awaddr; end
                if (s_axi_wvalid && wr) begin wh = 1; wd_m = s_axi_wdata; ws_m = s_axi_wstrb; end
            end
            init_m = 1;
        end
    end

    // ---------------- driver ----------------
    task automatic txn(input bit do_w, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input int awd, input int wdd, input int bd,
                       input bit do_r, input logic [31:0] ra, input int ard, input int rd,
                       output logic [1:0] bresp, output logic [1:0] rresp,
                       output logic [31:0] rdata);
        int n = 0, bw = 0, rw = 0;
        bit awdn = !do_w, wdn = !do_w, bdn = !do_w, ardn = !do_r, rdn = !do_r;
        bresp = 2'bxx; rresp = 2'bxx; rdata = 'x;
        s_axi_awaddr = wa; s_axi_wdata = wd; s_axi_wstrb = ws; s_axi_araddr = ra;
        while (!(bdn && rdn) && n < 100) begin
            s_axi_awvalid = !awdn && n >= awd;
            s_axi_wvalid  = !wdn && n >= wdd;
            s_axi_arvalid = !ardn && n >= ard;
            s_axi_bready  = do_w && bw >= bd;
            s_axi_rready  = do_r && rw >= rd;
            @(negedge sys_clk);
            if (s_axi_awvalid && s_axi_awready) awdn = 1;
            if (s_axi_wvalid && s_axi_wready) wdn = 1;
            if (s_axi_arvalid && s_axi_arready) ardn = 1;
            if (!bdn && s_axi_bvalid) begin
                if (s_axi_bready) begin bdn = 1; bresp = s_axi_bresp; end
                else bw++;
            end
            if (!rdn && s_axi_rvalid) begin
                if (s_axi_rready) begin rdn = 1; rresp = s_axi_rresp; rdata = s_axi_rdata; end
                else rw++;
            end
            @(posedge sys_clk); #1;
            n++;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        s_axi_bready = 0; s_axi_rready = 0;
        chk("txn_completed", {bdn, rdn}, 2'b11);
    endtask

    task automatic do_reset(input int cycles);
        sys_resetn = 0;
        repeat (cycles) @(posedge sys_clk);
        #1 sys_resetn = 1;
    endtask

    logic [1:0]  br, rr;
    logic [31:0] rdv;
    logic [31:0] atab [10];

    initial begin
        atab[0] = BASE;            atab[1] = BASE + 32'h4;   atab[2] = BASE + 32'h8;
        atab[3] = BASE + 32'hC;    atab[4] = BASE + 32'h10;  atab[5] = BASE + 32'hFFC;
        atab[6] = BASE + 32'h1000; atab[7] = 32'h40000000;   atab[8] = BASE - 32'h4;
        atab[9] = BASE + 32'h3;

        @(posedge sys_clk);
        do_reset(10);
        @(posedge sys_clk); #1;
        chk("readies_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        chk("led_after_reset", led_pins, 4'h0);

        txn(1, BASE, 32'hA, 4'hF, 0, 0, 0, 0, 0, 0, 0, br, rr, rdv);
        chk("wr_led_a_bresp", br, OKAY);
        chk("wr_led_a_pins", led_pins, 4'b1010);

        txn(1, BASE, 32'h5, 4'h1, 2, 0, 0, 0, 0, 0, 0, br, rr, rdv);
        chk("w_before_aw_bresp", br, OKAY);
        chk("w_before_aw_pins", led_pins, 4'b0101);

        txn(1, BASE + 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 5, 0, 0, 0, 0, br, rr, rdv);
        chk("wr_id_bresp", br, SLVERR);
        chk("wr_id_pins", led_pins, 4'b0101);

        txn(0, 0, 0, 0, 0, 0, 0, 1, BASE + 32'h4, 0, 0, br, rr, rdv);
        chk("rd_id_rresp", rr, OKAY);
        chk("rd_id_rdata", rdv, ID_VAL);

        txn(0, 0, 0, 0, 0, 0, 0, 1, BASE + 32'h10, 0, 5, br, rr, rdv);
        chk("rd_unmapped_rresp", rr, SLVERR);
        chk("rd_unmapped_rdata", rdv, 32'h0);
        txn(0, 0, 0, 0, 0, 0, 0, 1, 32'h40000000, 0, 5, br, rr, rdv);
        chk("rd_outside_rresp", rr, SLVERR);
        chk("rd_outside_rdata", rdv, 32'h0);

        // AW accepted, then reset: nothing may come back afterwards
        s_axi_awaddr = BASE; s_axi_awvalid = 1;
        @(posedge sys_clk); #1;
        s_axi_awvalid = 0;
        do_reset(3);
        repeat (3) @(posedge sys_clk);
        #1 chk("no_resp_after_reset", {s_axi_bvalid, led_pins}, 5'd0);

        txn(1, BASE, 32'h9, 4'h1, 0, 0, 0, 0, 0, 0, 0, br, rr, rdv);
        txn(1, BASE, 32'h6, 4'hF, 1, 0, 1, 0, 0, 0, 0, br, rr, rdv);
        txn(1, BASE, 32'hC, 4'h3, 0, 1, 0, 0, 0, 0, 0, br, rr, rdv);
        txn(1, BASE, 32'hF, 4'hE, 0, 0, 0, 0, 0, 0, 0, br, rr, rdv);
        chk("strb0_bresp", br, OKAY);
        chk("strb0_pins", led_pins, 4'hC);
        txn(0, 0, 0, 0, 0, 0, 0, 1, BASE + 32'h8, 0, 0, br, rr, rdv);
`ifdef AXI_LED_TXN_CNT_EN
        chk("cnt_rresp", rr, OKAY);
        chk("cnt_rdata", rdv, 32'd4);
`else
        chk("cnt_rresp", rr, SLVERR);
        chk("cnt_rdata", rdv, 32'd0);
`endif

        // AR handshake on the same edge the write commits
        txn(1, BASE, 32'h3, 4'h1, 0, 0, 0, 1, BASE, 1, 0, br, rr, rdv);
        chk("simul_rdata_old", rdv, 32'hC);
        chk("simul_pins_new", led_pins, 4'h3);

        for (int i = 0; i < 200; i++) begin
            bit dw, dr;
            dw = $urandom_range(0, 1);
            dr = $urandom_range(0, 1);
            if (!dw && !dr) dw = 1;
            txn(dw, atab[$urandom_range(0, 9)], $urandom, 4'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                dr, atab[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3),
                br, rr, rdv);
        end

        repeat (2) @(posedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
